coverfloat_vector_streamer: RTL and testbench



---
 rtl/coverfloat_vector_streamer.sv | 214 +++++++++++++++++++++
 tb/tb_coverfloat_vector_streamer.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/coverfloat_vector_streamer.sv
// Streams packed cover vectors from a 1-cycle-latency memory through a 2-entry queue,
// presenting the unpacked head fields under a valid/ready handshake.
module coverfloat_vector_streamer #(
    parameter int unsigned OP_W   = 32,
    parameter int unsigned RM_W   = 8,
    parameter int unsigned OPND_W = 128,
    parameter int unsigned FMT_W  = 8,
    parameter int unsigned INTX_W = 32,
    parameter int unsigned INTM_W = 192,
    parameter int unsigned EXC_W  = 8,
    parameter int unsigned ADDR_W = 14,
    localparam int unsigned VEC_W = OP_W + RM_W + 4 * OPND_W + 4 * FMT_W + 1 + INTX_W
                                    + INTM_W + EXC_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W:0]   num_vectors,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [VEC_W-1:0]  rd_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [OP_W-1:0]   op,
    output logic [RM_W-1:0]   rm,
    output logic [OPND_W-1:0] a,
    output logic [OPND_W-1:0] b,
    output logic [OPND_W-1:0] c,
    output logic [FMT_W-1:0]  aFmt,
    output logic [FMT_W-1:0]  bFmt,
    output logic [FMT_W-1:0]  cFmt,
    output logic [OPND_W-1:0] result,
    output logic [FMT_W-1:0]  resultFmt,
    output logic              intermS,
    output logic [INTX_W-1:0] intermX,
    output logic [INTM_W-1:0] intermM,
    output logic [EXC_W-1:0]  exceptionBits,
    output logic              busy,
    output logic              done,
    output logic [31:0]       vec_count
);

    localparam int unsigned INTM_LO = EXC_W;
    localparam int unsigned INTX_LO = INTM_LO + INTM_W;
    localparam int unsigned INTS_LO = INTX_LO + INTX_W;
    localparam int unsigned RFMT_LO = INTS_LO + 1;
    localparam int unsigned RES_LO  = RFMT_LO + FMT_W;
    localparam int unsigned CFMT_LO = RES_LO + OPND_W;
    localparam int unsigned BFMT_LO = CFMT_LO + FMT_W;
    localparam int unsigned AFMT_LO = BFMT_LO + FMT_W;
    localparam int unsigned C_LO    = AFMT_LO + FMT_W;
    localparam int unsigned B_LO    = C_LO + OPND_W;
    localparam int unsigned A_LO    = B_LO + OPND_W;
    localparam int unsigned RM_LO   = A_LO + OPND_W;
    localparam int unsigned OP_LO   = RM_LO + RM_W;

    typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

    state_e              r_state;
    state_e              w_state_d;
    logic [ADDR_W:0]     r_num;
    logic [ADDR_W-1:0]   r_addr;
    logic                r_inflight;
    logic [VEC_W-1:0]    r_q0;
    logic [VEC_W-1:0]    r_q1;
    logic [1:0]          r_cnt;
    logic [31:0]         r_vec_count;
    logic                r_done;

    logic                w_abort;
    logic                w_start_ok;
    logic [ADDR_W:0]     w_num;
    logic                w_last;
    logic                w_sentinel;
    logic [1:0]          w_occ;
    logic                w_rd_en;
    logic                w_push;
    logic                w_pop;

    // Reset mid-run behaves like abort for the combinational strobes.
    assign w_abort    = abort || !rst_n;
    assign w_start_ok = (r_state == StIdle) && start && !w_abort;
    assign w_num      = (r_state == StIdle) ? num_vectors : r_num;
    assign w_last     = ({1'b0, r_addr} == (w_num - 1'b1));
    assign w_sentinel = r_inflight && (rd_data[OP_LO +: OP_W] == {OP_W{1'b1}});
    assign w_occ      = r_cnt + {1'b0, r_inflight};
    assign w_push     = r_inflight && !w_sentinel && !w_abort;
    assign w_pop      = (r_cnt != 2'd0) && out_ready && !w_abort;

    // The first read goes out in the start cycle so data is buffered two cycles later.
    always_comb begin
        w_state_d = r_state;
        w_rd_en   = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (w_start_ok) begin
                    if (num_vectors == '0) begin
                        w_state_d = StDone;
                    end else begin
                        w_rd_en   = 1'b1;
                        w_state_d = w_last ? StDrain : StRun;
                    end
                end
            end
            StRun: begin
                if (w_abort) begin
                    w_state_d = StIdle;
                end else if (w_sentinel) begin
                    w_state_d = StDrain;
                end else if (w_occ < 2'd2) begin
                    w_rd_en = 1'b1;
                    if (w_last) begin
                        w_state_d = StDrain;
                    end
                end
            end
            StDrain: begin
                if (w_abort) begin
                    w_state_d = StIdle;
                end else if ((r_cnt == 2'd0) && !r_inflight) begin
                    w_state_d = StDone;
                end
            end
            StDone: begin
                w_state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= StIdle;
            r_num       <= '0;
            r_addr      <= '0;
            r_inflight  <= 1'b0;
            r_q0        <= '0;
            r_q1        <= '0;
            r_cnt       <= 2'd0;
            r_vec_count <= 32'd0;
            r_done      <= 1'b0;
        end else begin
            r_state    <= w_state_d;
            r_inflight <= w_rd_en;
            r_done     <= (r_state == StDone) && !w_abort;

            if (w_start_ok) begin
                r_num       <= num_vectors;
                r_vec_count <= 32'd0;
            end else if (w_pop) begin
                r_vec_count <= r_vec_count + 32'd1;
            end

            // Address parks at the last issued read so it never wraps.
            if ((w_state_d == StIdle) || (w_state_d == StDone)) begin
                r_addr <= '0;
            end else if (w_rd_en && !w_last) begin
                r_addr <= r_addr + 1'b1;
            end

            if (w_abort) begin
                r_cnt <= 2'd0;
            end else begin
                case ({w_push, w_pop})
                    2'b10: begin
                        if (r_cnt == 2'd0) begin
                            r_q0 <= rd_data;
                        end else begin
                            r_q1 <= rd_data;
                        end
                        r_cnt <= r_cnt + 2'd1;
                    end
                    2'b01: begin
                        r_q0  <= r_q1;
                        r_cnt <= r_cnt - 2'd1;
                    end
                    2'b11: begin
                        if (r_cnt == 2'd1) begin
                            r_q0 <= rd_data;
                        end else begin
                            r_q0 <= r_q1;
                            r_q1 <= rd_data;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    assign rd_en         = w_rd_en;
    assign rd_addr       = r_addr;
    assign out_valid     = (r_cnt != 2'd0);
    assign busy          = (r_state != StIdle);
    assign done          = r_done;
    assign vec_count     = r_vec_count;

    assign op            = r_q0[OP_LO +: OP_W];
    assign rm            = r_q0[RM_LO +: RM_W];
    assign a             = r_q0[A_LO +: OPND_W];
    assign b             = r_q0[B_LO +: OPND_W];
    assign c             = r_q0[C_LO +: OPND_W];
    assign aFmt          = r_q0[AFMT_LO +: FMT_W];
    assign bFmt          = r_q0[BFMT_LO +: FMT_W];
    assign cFmt          = r_q0[CFMT_LO +: FMT_W];
    assign result        = r_q0[RES_LO +: OPND_W];
    assign resultFmt     = r_q0[RFMT_LO +: FMT_W];
    assign intermS       = r_q0[INTS_LO];
    assign intermX       = r_q0[INTX_LO +: INTX_W];
    assign intermM       = r_q0[INTM_LO +: INTM_W];
    assign exceptionBits = r_q0[EXC_W-1:0];

endmodule

// File: tb/tb_coverfloat_vector_streamer.sv
// Directed, table-driven bench for coverfloat_vector_streamer with a behavioural vector memory
// and a small occupancy model of the queue.
module tb_coverfloat_vector_streamer;

    localparam int VEC_W = 817;

    typedef struct packed {
        logic [31:0]  op;
        logic [7:0]   rm;
        logic [127:0] a;
        logic [127:0] b;
        logic [127:0] c;
        logic [7:0]   afmt;
        logic [7:0]   bfmt;
        logic [7:0]   cfmt;
        logic [127:0] res;
        logic [7:0]   resfmt;
        logic         s;
        logic [31:0]  x;
        logic [191:0] m;
        logic [7:0]   exc;
    } fld_t;

    typedef struct {
        int         num;
        logic [3:0] pat;
        int         sent;
        int         exp_n;
        int         exp_first;
        int         exp_done;
    } vec_t;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic             abort;
    logic [14:0]      num_vectors;
    logic             rd_en;
    logic [13:0]      rd_addr;
    logic [VEC_W-1:0] rd_data = '0;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      op;
    logic [7:0]       rm;
    logic [127:0]     a;
    logic [127:0]     b;
    logic [127:0]     c;
    logic [7:0]       aFmt;
    logic [7:0]       bFmt;
    logic [7:0]       cFmt;
    logic [127:0]     result;
    logic [7:0]       resultFmt;
    logic             intermS;
    logic [31:0]      intermX;
    logic [191:0]     intermM;
    logic [7:0]       exceptionBits;
    logic             busy;
    logic             done;
    logic [31:0]      vec_count;

    logic [VEC_W-1:0] mem [32];
    fld_t             w_cat;
    int               n_cmp = 0;
    int               n_bad = 0;
    vec_t             tbl [7];

    coverfloat_vector_streamer dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .abort         (abort),
        .num_vectors   (num_vectors),
        .rd_en         (rd_en),
        .rd_addr       (rd_addr),
        .rd_data       (rd_data),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .op            (op),
        .rm            (rm),
        .a             (a),
        .b             (b),
        .c             (c),
        .aFmt          (aFmt),
        .bFmt          (bFmt),
        .cFmt          (cFmt),
        .result        (result),
        .resultFmt     (resultFmt),
        .intermS       (intermS),
        .intermX       (intermX),
        .intermM       (intermM),
        .exceptionBits (exceptionBits),
        .busy          (busy),
        .done          (done),
        .vec_count     (vec_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rd_en) rd_data <= mem[rd_addr[4:0]];
    end

    assign w_cat = {op, rm, a, b, c, aFmt, bFmt, cFmt, result, resultFmt, intermS, intermX,
                    intermM, exceptionBits};

    function automatic fld_t mk(input int idx);
        fld_t f;
        logic [31:0] v;
        v        = 32'(idx);
        f.op     = 32'hA500_0000 | v;
        f.rm     = 8'h10 + v[7:0];
        f.a      = {4{32'hAAAA_0000 | v}};
        f.b      = {4{32'hBBBB_0000 | v}};
        f.c      = {4{32'hCCCC_0000 | v}};
        f.afmt   = 8'h20 + v[7:0];
        f.bfmt   = 8'h40 + v[7:0];
        f.cfmt   = 8'h60 + v[7:0];
        f.res    = {4{32'hDDDD_0000 | v}};
        f.resfmt = 8'h80 + v[7:0];
        f.s      = v[0];
        f.x      = 32'h1234_0000 | v;
        f.m      = {6{32'hEEEE_0000 | v}};
        f.exc    = 8'hC0 + v[7:0];
        return f;
    endfunction

    function automatic bit is_sent(input int idx);
        logic [31:0] v;
        v = 32'(idx);
        return mem[v[4:0]][VEC_W-1 -: 32] == 32'hFFFF_FFFF;
    endfunction

    task automatic load_mem(input int sent);
        for (int i = 0; i < 32; i++) begin
            mem[i] = mk(i);
            if (i == sent) mem[i][VEC_W-1 -: 32] = 32'hFFFF_FFFF;
        end
    endtask

    task automatic chk(input string nm, input logic [191:0] act, input logic [191:0] want);
        n_cmp++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, want);
        end
    endtask

    task automatic chk_fields(input int idx);
        fld_t e;
        e = mk(idx);
        chk("op", 192'(op), 192'(e.op));
        chk("rm", 192'(rm), 192'(e.rm));
        chk("a", 192'(a), 192'(e.a));
        chk("b", 192'(b), 192'(e.b));
        chk("c", 192'(c), 192'(e.c));
        chk("aFmt", 192'(aFmt), 192'(e.afmt));
        chk("bFmt", 192'(bFmt), 192'(e.bfmt));
        chk("cFmt", 192'(cFmt), 192'(e.cfmt));
        chk("result", 192'(result), 192'(e.res));
        chk("resultFmt", 192'(resultFmt), 192'(e.resfmt));
        chk("intermS", 192'(intermS), 192'(e.s));
        chk("intermX", 192'(intermX), 192'(e.x));
        chk("intermM", intermM, e.m);
        chk("exceptionBits", 192'(exceptionBits), 192'(e.exc));
    endtask

    // Full run: cycle 0 is the start cycle; inputs change on negedge, outputs sampled 1 later.
    task automatic run_case(input vec_t v);
        int   occ, got, done_cnt, done_cyc, first, prev_addr;
        logic prev_rd, prev_stall;
        fld_t snap;
        bit   fin;
        load_mem(v.sent);
        occ = 0; got = 0; done_cnt = 0; done_cyc = -1; first = -1; prev_addr = 0;
        prev_rd = 1'b0; prev_stall = 1'b0; snap = '0; fin = 1'b0;
        @(negedge clk);
        start       = 1'b1;
        num_vectors = 15'(v.num);
        out_ready   = v.pat[0];
        for (int cyc = 0; cyc < 400 && !fin; cyc++) begin
            #1;
            if (rd_en) begin
                chk("issue_rule", 192'((occ + int'(prev_rd)) < 2), 192'(1));
                chk("addr_range", 192'(int'(rd_addr) < v.num), 192'(1));
            end
            chk("valid_vs_occupancy", 192'(out_valid), 192'(occ > 0));
            if (prev_stall) begin
                chk("stall_valid", 192'(out_valid), 192'(1));
                chk("stall_hold", 192'(w_cat == snap), 192'(1));
            end
            if (out_valid && out_ready) begin
                chk_fields(got);
                got++;
            end
            if (out_valid && first < 0) first = cyc;
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            occ = occ + ((prev_rd && !is_sent(prev_addr)) ? 1 : 0)
                      - ((out_valid && out_ready) ? 1 : 0);
            prev_stall = out_valid && !out_ready;
            snap       = w_cat;
            prev_rd    = rd_en;
            prev_addr  = int'(rd_addr);
            if (done_cnt > 0 && cyc >= done_cyc + 3) fin = 1'b1;
            @(negedge clk);
            start     = 1'b0;
            out_ready = v.pat[(cyc + 1) % 4];
        end
        chk("run_terminated", 192'(fin), 192'(1));
        chk("handshakes", 192'(got), 192'(v.exp_n));
        chk("vec_count", 192'(vec_count), 192'(v.exp_n));
        chk("done_pulses", 192'(done_cnt), 192'(1));
        if (v.exp_first >= 0) chk("first_valid_cycle", 192'(first), 192'(v.exp_first));
        else chk("never_valid", 192'(first == -1), 192'(1));
        if (v.exp_done >= 0) chk("done_cycle", 192'(done_cyc), 192'(v.exp_done));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int   dcnt;
        vec_t v2;
        tbl[0] = '{4, 4'b1111, -1, 4, 2, -1};
        tbl[1] = '{4, 4'b1001, -1, 4, 2, -1};
        tbl[2] = '{10, 4'b1111, 3, 3, 2, -1};
        tbl[3] = '{0, 4'b1111, -1, 0, -1, 2};
        tbl[4] = '{1, 4'b0110, -1, 1, 2, -1};
        tbl[5] = '{6, 4'b1111, 0, 0, -1, -1};
        tbl[6] = '{16, 4'b1011, -1, 16, 2, -1};

        rst_n = 1'b0; start = 1'b0; abort = 1'b0; num_vectors = '0; out_ready = 1'b0;
        load_mem(-1);
        repeat (2) @(negedge clk);
        #1;
        chk("rst_busy", 192'(busy), 192'(0));
        chk("rst_done", 192'(done), 192'(0));
        chk("rst_valid", 192'(out_valid), 192'(0));
        chk("rst_rd_en", 192'(rd_en), 192'(0));
        chk("rst_rd_addr", 192'(rd_addr), 192'(0));
        chk("rst_vec_count", 192'(vec_count), 192'(0));
        chk("rst_op", 192'(op), 192'(0));
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 7; i++) run_case(tbl[i]);

        // Abort with two vectors buffered, start in the same cycle must be ignored.
        load_mem(-1);
        @(negedge clk);
        start = 1'b1; num_vectors = 15'd8; out_ready = 1'b0;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("abort_pre_valid", 192'(out_valid), 192'(1));
        chk("abort_pre_rd_en", 192'(rd_en), 192'(0));
        abort = 1'b1; start = 1'b1; num_vectors = 15'd2;
        @(negedge clk);
        abort = 1'b0; start = 1'b0;
        #1;
        chk("abort_valid", 192'(out_valid), 192'(0));
        chk("abort_busy", 192'(busy), 192'(0));
        chk("abort_rd_en", 192'(rd_en), 192'(0));
        chk("abort_vec_count", 192'(vec_count), 192'(0));
        dcnt = 0;
        for (int i = 0; i < 4; i++) begin
            if (done || busy) dcnt++;
            @(negedge clk);
            #1;
        end
        chk("abort_quiet", 192'(dcnt), 192'(0));
        v2 = '{2, 4'b1111, -1, 2, 2, -1};
        run_case(v2);

        // Reset mid-run after one handshake, then the same run again from address 0.
        load_mem(-1);
        @(negedge clk);
        start = 1'b1; num_vectors = 15'd4; out_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("pre_reset_vec_count", 192'(vec_count), 192'(1));
        rst_n = 1'b0;
        @(negedge clk);
        #1;
        chk("mid_rst_busy", 192'(busy), 192'(0));
        chk("mid_rst_valid", 192'(out_valid), 192'(0));
        chk("mid_rst_rd_en", 192'(rd_en), 192'(0));
        chk("mid_rst_rd_addr", 192'(rd_addr), 192'(0));
        chk("mid_rst_done", 192'(done), 192'(0));
        chk("mid_rst_vec_count", 192'(vec_count), 192'(0));
        chk("mid_rst_op", 192'(op), 192'(0));
        chk("mid_rst_intermM", intermM, 192'(0));
        rst_n = 1'b1;
        run_case(tbl[0]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
